oam_dma: RTL and testbench

Bus-side companion to the Game Boy CPU core: sits directly downstream of the CPU's external bus (`a`/`dout`/`din`/`rd`/`wr`/`phi`), splits it into a memory port (0000–FEFF) and an I/O port (FF00–FFFF), and owns the DMA register FF46. A write to FF46 copies 160 bytes from `{src,8'h00}` to OAM through a dedicated OAM write port, one byte per M-cycle. While the copy runs, the CPU is locked out of the memory port.

---
 rtl/oam_dma_pkg.sv | 21 ++
 rtl/oam_dma_mcycle.sv | 34 +++
 rtl/oam_dma.sv | 160 ++++++++++++++++
 tb/tb_oam_dma.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared constants, state encoding and source-address helper for the OAM DMA block.
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam int unsigned OAM_LEN      = 160;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;
  localparam logic [7:0]  LAST_IDX     = 8'(OAM_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_e;

  // Sources in echo RAM (E000-FFFF) alias down to C000-DFFF.
  function automatic logic [7:0] eff_src_hi(input logic [7:0] src);
    return (src >= ECHO_BASE) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_mcycle.sv
// Recovers the M-cycle phase (1,2,3,0) from the CPU's phi clock, which is high in phases 1-2.
module mcycle_tracker
  import oam_dma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_phi,
  output logic [1:0] phase,
  output logic       phase0_pulse
);

  logic       phi_q, phi_d;
  logic [1:0] phase_q, phase_d;

  // phase_d is the phase of the current clk; phase_q remembers the previous one.
  always_comb begin
    phi_d   = cpu_phi;
    phase_d = (cpu_phi && !phi_q) ? 2'd1 : phase_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phi_q   <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      phi_q   <= phi_d;
      phase_q <= phase_d;
    end
  end

  assign phase        = phase_d;
  assign phase0_pulse = (phase_d == 2'd0);

endmodule

// File: rtl/oam_dma.sv
// CPU bus splitter (memory / I/O) owning FF46; copies 160 bytes into OAM, one per M-cycle.
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_phi,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  io_a,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  logic [1:0] phase;
  logic       phase0_pulse;

  mcycle_tracker u_mcycle (
    .clk          (clk),
    .rst          (rst),
    .cpu_phi      (cpu_phi),
    .phase        (phase),
    .phase0_pulse (phase0_pulse)
  );

  dma_state_e state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dbuf_q, dbuf_d;
  logic       armed_q, armed_d;
  logic       oam_we_q, oam_we_d;
  logic [7:0] oam_a_q, oam_a_d;
  logic [7:0] oam_wdata_q, oam_wdata_d;

  logic       is_dma_reg, is_io, dma_wr, active, xfer_rd;
  logic [7:0] src_h;

  assign is_dma_reg = (cpu_a == DMA_REG_ADDR);
  assign is_io      = (cpu_a >= IO_BASE);
  assign dma_wr     = cpu_wr && is_dma_reg;
  assign active     = (state_q != ST_IDLE);
  assign src_h      = eff_src_hi(src_q);
  assign xfer_rd    = (state_q == ST_XFER) && (phase != 2'd3);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    dbuf_d      = dbuf_q;
    armed_d     = armed_q;
    oam_we_d    = 1'b0;
    oam_a_d     = oam_a_q;
    oam_wdata_d = oam_wdata_q;

    case (state_q)
      ST_IDLE: ;
      // armed_q marks the first phase 0 seen; the second one ends the delay M-cycle.
      ST_START: begin
        if (phase0_pulse) begin
          if (armed_q) begin
            state_d = ST_XFER;
            armed_d = 1'b0;
          end else begin
            armed_d = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (phase == 2'd2) begin
          dbuf_d      = mem_rdata;
          oam_we_d    = 1'b1;
          oam_a_d     = idx_q;
          oam_wdata_d = mem_rdata;
        end
        if (phase == 2'd3) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A register write wins over everything, including a write about to reach OAM.
    if (dma_wr) begin
      src_d    = cpu_dout;
      idx_d    = 8'd0;
      armed_d  = 1'b0;
      state_d  = ST_START;
      oam_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      src_q       <= 8'd0;
      idx_q       <= 8'd0;
      dbuf_q      <= 8'd0;
      armed_q     <= 1'b0;
      oam_we_q    <= 1'b0;
      oam_a_q     <= 8'd0;
      oam_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      dbuf_q      <= dbuf_d;
      armed_q     <= armed_d;
      oam_we_q    <= oam_we_d;
      oam_a_q     <= oam_a_d;
      oam_wdata_q <= oam_wdata_d;
    end
  end

  always_comb begin
    mem_a     = cpu_a;
    mem_wdata = cpu_dout;
    mem_rd    = cpu_rd && !is_io;
    mem_wr    = cpu_wr && !is_io;
    if (active) begin
      mem_a  = {src_h, idx_q};
      mem_rd = xfer_rd;
      mem_wr = 1'b0;
    end

    io_a     = cpu_a[7:0];
    io_wdata = cpu_dout;
    io_rd    = cpu_rd && is_io && !is_dma_reg;
    io_wr    = cpu_wr && is_io && !is_dma_reg;

    if (is_dma_reg)  cpu_din = src_q;
    else if (is_io)  cpu_din = io_rdata;
    else if (active) cpu_din = 8'hFF;
    else             cpu_din = mem_rdata;
  end

  assign oam_we     = oam_we_q;
  assign oam_a      = oam_a_q;
  assign oam_wdata  = oam_wdata_q;
  assign dma_active = active;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: bus memory/OAM models, phi generator and hand-computed expectations.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_phi = 1'b0;
  logic [15:0] mem_a;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rd, mem_wr;
  logic [7:0]  io_a, io_wdata, io_rdata;
  logic        io_rd, io_wr;
  logic [7:0]  oam_a, oam_wdata;
  logic        oam_we, dma_active;

  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:255];

  int n_tests = 0;
  int n_fail  = 0;
  int tb_ph   = 0;
  int we_cnt, we_bad_ph, act_clks, act_mc;
  logic [15:0] rd_q [$];

  oam_dma dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_phi    (cpu_phi),
    .mem_a      (mem_a),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .io_a       (io_a),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .oam_a      (oam_a),
    .oam_wdata  (oam_wdata),
    .oam_we     (oam_we),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_a];
  assign io_rdata  = io_a ^ 8'h3C;

  // phi high in phases 1-2; tb_ph is the bench's own phase of the current clk.
  initial forever begin
    @(posedge clk);
    #1;
    tb_ph   = (tb_ph + 1) % 4;
    cpu_phi = (tb_ph == 1) || (tb_ph == 2);
  end

  always @(negedge clk) begin
    if (oam_we) begin
      oam[oam_a] = oam_wdata;
      we_cnt++;
      if (tb_ph != 3) we_bad_ph++;
    end
    if (dma_active) begin
      act_clks++;
      if (tb_ph == 1) act_mc++;
    end
    if (dma_active && mem_rd && tb_ph == 2) rd_q.push_back(mem_a);
    if (mem_wr) mem[mem_a] = mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 8; i++) begin
      step();
      if (tb_ph == p) return;
    end
    check_eq("wait_ph_timeout", tb_ph, p);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_a    = a;
    cpu_dout = d;
    cpu_wr   = 1'b1;
    step();
    cpu_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!dma_active) return;
      step();
    end
    check_eq("dma_done_timeout", dma_active, 1'b0);
  endtask

  task automatic wait_we(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (we_cnt >= n) return;
      step();
    end
    check_eq("we_count_timeout", we_cnt, n);
  endtask

  task automatic clear_counts();
    we_cnt = 0; we_bad_ph = 0; act_clks = 0; act_mc = 0;
    rd_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
      mem[16'hC300 + i] = 8'(i) ^ 8'hA5;
      mem[16'h8000 + i] = 8'(i) ^ 8'h33;
      mem[16'h9000 + i] = ~8'(i);
    end
    mem[16'h4000] = 8'h77;
    mem[16'h0150] = 8'h5C;
    mem[16'hC000] = 8'h11;
    clear_counts();

    // Reset state
    repeat (4) step();
    check_eq("rst_dma_active", dma_active, 1'b0);
    check_eq("rst_oam_we", oam_we, 1'b0);
    check_eq("rst_oam_a", oam_a, 8'h00);
    check_eq("rst_oam_wdata", oam_wdata, 8'h00);
    cpu_a = 16'hFF46;
    #1 check_eq("rst_ff46_read", cpu_din, 8'h00);
    rst = 1'b1;
    repeat (8) step();

    // Idle routing
    cpu_a = 16'h4000; cpu_rd = 1'b1;
    #1;
    check_eq("idle_mem_rd", mem_rd, 1'b1);
    check_eq("idle_cpu_din", cpu_din, 8'h77);
    check_eq("idle_io_rd", io_rd, 1'b0);
    cpu_rd = 1'b0;
    cpu_a = 16'hFF40; cpu_dout = 8'h12; cpu_wr = 1'b1;
    #1;
    check_eq("idle_io_wr", io_wr, 1'b1);
    check_eq("idle_io_a", io_a, 8'h40);
    check_eq("idle_io_wdata", io_wdata, 8'h12);
    check_eq("idle_mem_wr", mem_wr, 1'b0);
    step();
    cpu_wr = 1'b0;

    // Basic copy from C100
    clear_counts();
    wait_ph(2);
    cpu_write(16'hFF46, 8'hC1);
    check_eq("start_latency", dma_active, 1'b1);
    wait_idle(800);
    check_eq("end_phase", tb_ph, 0);
    check_eq("basic_act_clks", act_clks, 645);
    check_eq("basic_act_mcycles", act_mc, 161);
    check_eq("basic_we_count", we_cnt, 160);
    check_eq("basic_we_phase", we_bad_ph, 0);
    errs = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) errs++;
    check_eq("basic_oam_data", errs, 0);

    // Lockout during a transfer
    clear_counts();
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    wait_ph(2);
    cpu_write(16'hFF46, 8'hC1);
    repeat (10) step();
    cpu_a = 16'h0150; cpu_rd = 1'b1;
    #1 check_eq("lock_read_ff", cpu_din, 8'hFF);
    cpu_rd = 1'b0;
    cpu_a = 16'hC000; cpu_dout = 8'hEE; cpu_wr = 1'b1;
    #1 check_eq("lock_mem_wr", mem_wr, 1'b0);
    step();
    cpu_wr = 1'b0;
    cpu_a = 16'hFF90; cpu_rd = 1'b1;
    #1;
    check_eq("lock_io_rd", io_rd, 1'b1);
    check_eq("lock_io_a", io_a, 8'h90);
    check_eq("lock_io_din", cpu_din, 8'hAC);
    cpu_rd = 1'b0;
    cpu_dout = 8'h21; cpu_wr = 1'b1;
    #1 check_eq("lock_io_wr", io_wr, 1'b1);
    step();
    cpu_wr = 1'b0;
    cpu_a = 16'hFF46;
    #1 check_eq("lock_ff46_read", cpu_din, 8'hC1);
    wait_idle(800);
    check_eq("lock_we_count", we_cnt, 160);
    check_eq("lock_c000_kept", mem[16'hC000], 8'h11);
    errs = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) errs++;
    check_eq("lock_oam_data", errs, 0);

    // Echo source E3 -> C3xx
    clear_counts();
    wait_ph(2);
    cpu_write(16'hFF46, 8'hE3);
    wait_idle(800);
    check_eq("echo_rd_count", rd_q.size(), 160);
    errs = 0;
    for (int k = 0; k < rd_q.size(); k++) if (rd_q[k] !== (16'hC300 + 16'(k))) errs++;
    check_eq("echo_mem_a_seq", errs, 0);
    errs = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'hA5)) errs++;
    check_eq("echo_oam_data", errs, 0);
    cpu_a = 16'hFF46;
    #1 check_eq("echo_ff46_read", cpu_din, 8'hE3);

    // Restart after 20 bytes
    clear_counts();
    wait_ph(2);
    cpu_write(16'hFF46, 8'h80);
    wait_we(20, 300);
    wait_ph(2);
    cpu_write(16'hFF46, 8'h90);
    wait_idle(800);
    check_eq("restart_we_count", we_cnt, 180);
    errs = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== ~8'(i)) errs++;
    check_eq("restart_oam_data", errs, 0);

    // Reset in the middle of a transfer
    clear_counts();
    wait_ph(2);
    cpu_write(16'hFF46, 8'hC1);
    wait_we(50, 400);
    rst = 1'b0;
    step();
    check_eq("midrst_dma_active", dma_active, 1'b0);
    check_eq("midrst_oam_we", oam_we, 1'b0);
    cpu_a = 16'hFF46;
    #1 check_eq("midrst_ff46_read", cpu_din, 8'h00);
    rst = 1'b1;
    repeat (8) step();
    check_eq("midrst_we_frozen", we_cnt, 50);
    cpu_a = 16'h0150; cpu_rd = 1'b1;
    #1;
    check_eq("midrst_mem_rd", mem_rd, 1'b1);
    check_eq("midrst_mem_a", mem_a, 16'h0150);
    check_eq("midrst_cpu_din", cpu_din, 8'h5C);
    cpu_rd = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
